fm_param_fetcher: RTL and testbench
===================================

// Module: fm_param_fetcher
// PURPOSE
// - Read-side master for the external flash memory holding the network parameters.
// - On a start request it fetches one neuron's bias and weight words, then hands them one at a time to the MAC datapath over a valid/ready stream.
// - It drives the chip-enable, output-enable, write-enable and address lines and samples the 16-bit flash data bus.
// - It sits between the flash pins and the hidden/output neuron compute units.
// PARAMETERS
// - ADDR_W       16  flash address width.
// - DATA_W       16  flash word width.
// - WAIT_CYCLES   2  clocks the address must be stable before data is sampled (range 1..15).
// - N_HIDDEN      8  number of hidden neurons.
// - HID_WORDS    36  weight words per hidden neuron (4 signed nibbles per word).
// - N_OUT        10  number of output neurons.
// - OUT_WORDS     2  weight words per output neuron.
// PORTS
// - clk          in   1       system clock; all logic is rising-edge.
// - rst          in   1       asynchronous, active-high reset.
// - start        in   1       one-cycle request; sampled only in IDLE.
// - layer_sel    in   1       0 = hidden layer, 1 = output layer.
// - neuron_idx   in   4       neuron number within the selected layer.
// - busy         out  1       high from the accepted start until done.
// - done         out  1       one-cycle pulse after the last word is accepted downstream.
// - err          out  1       one-cycle pulse when a start has an out-of-range neuron_idx.
// - fm_ce        out  1       flash chip enable, active-high.
// - fm_oe        out  1       flash output enable, active-high.
// - fm_we        out  1       flash write enable, active-high; tied to 0.
// - fm_addr      out  ADDR_W  flash word address.
// - fm_data      in   DATA_W  flash read data.
// - out_valid    out  1       out_data is valid.
// - out_ready    in   1       downstream accepts the word.
// - out_data     out  DATA_W  captured word.
// - out_is_bias  out  1       the current word is the neuron's bias.
// - out_last     out  1       the current word is the neuron's final weight word.
// BEHAVIOUR
// - Reset values: every output is 0, fm_addr is 0, and the FSM is in IDLE.
// - Asserting rst mid-fetch aborts immediately: no done pulse, and the partial stream is discarded.
// - Flash map: a hidden neuron n has base n*37 (bias, then 36 weights). An output neuron m has base 296+m*3 (bias, then 2 weights). The last address is 325.
// - Word count per fetch: HID_WORDS+1 for the hidden layer, OUT_WORDS+1 for the output layer. The address computation is unsigned and ADDR_W wide.
// - A start in IDLE with idx >= N_HIDDEN (hidden) or idx >= N_OUT (output):
//   - err pulses the next cycle;
//   - the FSM stays in IDLE and no flash access is made.
// - A start while busy is ignored, with no err.
// - IDLE -> SETUP on a valid start. Latch base and count; busy = 1.
// - SETUP: drive fm_addr, fm_ce = 1, fm_oe = 1. Load the wait counter with WAIT_CYCLES-1. Go to WAIT.
// - WAIT: decrement the counter. At 0 go to CAPTURE. fm_addr, ce and oe are held stable throughout.
// - CAPTURE: register fm_data into out_data and set out_valid = 1. Set out_is_bias if the word offset is 0, and out_last if the offset is count-1. Drop fm_oe, then go to PRESENT.
// - PRESENT: hold out_data and its flags until out_valid && out_ready.
//   - On acceptance: clear out_valid.
//   - If it was the last word: go to DONE.
//   - Otherwise: advance the address by 1 and go to SETUP.
// - DONE: pulse done, clear busy, fm_ce = 0, go to IDLE. A start arriving in DONE is ignored.
// - out_data, out_is_bias and out_last must not change while out_valid && !out_ready.
// - Throughput with out_ready tied high: WAIT_CYCLES+3 clocks per word.
// - Latency: start to first out_valid is WAIT_CYCLES+2 clocks.
// - fm_we is never asserted, so the block never writes the flash.
// STRUCTURE
// - Package fm_pkg holds:
//   - the FSM state enum (IDLE, SETUP, WAIT, CAPTURE, PRESENT, DONE);
//   - constants HID_STRIDE=37, OUT_BASE=296, OUT_STRIDE=3, FM_LAST_ADDR=325.
// - One sub-module, fm_wait_counter: loadable down-counter with a zero flag, used for the WAIT state.
// - Everything else lives in this module.
// TESTING
// - Hidden, idx 0, out_ready = 1:
//   - addresses 0..36 are issued in order;
//   - 37 words are delivered, matching the flash contents;
//   - out_is_bias on word 0 only, out_last on word 36, then one done pulse.
// - Output, idx 9:
//   - addresses 323, 324, 325 are issued;
//   - 3 words, bias first; done after the 3rd acceptance.
// - Backpressure: hidden idx 7 with out_ready low for 5 cycles on every 2nd word.
//   - out_data stays stable while stalled;
//   - addresses 259..295 are issued, with none skipped or repeated.
// - Invalid requests, each giving one err pulse, no fm_ce, busy = 0:
//   - hidden idx 8;
//   - output idx 10.
// - Start while busy: a second start during the hidden idx 2 fetch is ignored, and only addresses 74..110 appear.
// - Reset mid-fetch at word 5: all outputs are 0 next cycle, and there is no done. A fresh start of output idx 0 then fetches addresses 296..298.

Source files
------------

// File: rtl/fm_pkg.sv
// Shared types and flash-map constants for the parameter fetcher.
// Hidden neurons are packed from address 0; output neurons follow them.
package fm_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StWait,
        StCapture,
        StPresent,
        StDone
    } fm_state_e;

    localparam int unsigned HID_STRIDE   = 37;
    localparam int unsigned OUT_BASE     = 296;
    localparam int unsigned OUT_STRIDE   = 3;
    localparam int unsigned FM_LAST_ADDR = 325;

endpackage

// File: rtl/fm_wait_counter.sv
// Loadable down-counter with a zero flag.
// Times how long the flash address is held before data is sampled.
module fm_wait_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fm_param_fetcher.sv
// Flash read master: fetches one neuron's bias and weights and streams them
// to the MAC datapath over a valid/ready interface.
module fm_param_fetcher
    import fm_pkg::*;
#(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned N_HIDDEN    = 8,
    parameter int unsigned HID_WORDS   = 36,
    parameter int unsigned N_OUT       = 10,
    parameter int unsigned OUT_WORDS   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              layer_sel_i,
    input  logic [3:0]        neuron_idx_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic              fm_ce_o,
    output logic              fm_oe_o,
    output logic              fm_we_o,
    output logic [ADDR_W-1:0] fm_addr_o,
    input  logic [DATA_W-1:0] fm_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_is_bias_o,
    output logic              out_last_o
);

    localparam int unsigned MAX_WORDS = (HID_WORDS > OUT_WORDS) ? HID_WORDS : OUT_WORDS;
    localparam int unsigned CNT_W     = $clog2(MAX_WORDS + 2);

    fm_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]  word_q, word_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              bias_q, bias_d;
    logic              last_q, last_d;

    logic              wc_load, wc_dec, wc_zero;
    logic              idx_ok, start_ok;
    logic [31:0]       base_calc, words_calc;

    fm_wait_counter #(
        .CNT_W(4)
    ) u_wait_counter (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (wc_load),
        .load_val_i(4'(WAIT_CYCLES - 1)),
        .dec_i     (wc_dec),
        .zero_o    (wc_zero)
    );

    // Request decode; the map-end guard only matters if the layer sizes are re-parameterised.
    always_comb begin
        if (layer_sel_i) begin
            idx_ok     = (32'(neuron_idx_i) < N_OUT);
            base_calc  = OUT_BASE + 32'(neuron_idx_i) * OUT_STRIDE;
            words_calc = OUT_WORDS + 1;
        end else begin
            idx_ok     = (32'(neuron_idx_i) < N_HIDDEN);
            base_calc  = 32'(neuron_idx_i) * HID_STRIDE;
            words_calc = HID_WORDS + 1;
        end
        start_ok = idx_ok && ((base_calc + words_calc - 32'd1) <= FM_LAST_ADDR);
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        word_d  = word_q;
        count_d = count_q;
        err_d   = 1'b0;
        valid_d = valid_q;
        data_d  = data_q;
        bias_d  = bias_q;
        last_d  = last_q;
        wc_load = 1'b0;
        wc_dec  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (start_ok) begin
                        state_d = StSetup;
                        addr_d  = ADDR_W'(base_calc);
                        word_d  = '0;
                        count_d = CNT_W'(words_calc);
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StSetup: begin
                wc_load = 1'b1;
                state_d = StWait;
            end
            StWait: begin
                if (wc_zero) begin
                    state_d = StCapture;
                end else begin
                    wc_dec = 1'b1;
                end
            end
            StCapture: begin
                valid_d = 1'b1;
                data_d  = fm_data_i;
                bias_d  = (word_q == '0);
                last_d  = (word_q == (count_q - CNT_W'(1)));
                state_d = StPresent;
            end
            StPresent: begin
                if (out_ready_i) begin
                    valid_d = 1'b0;
                    if (last_q) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        word_d  = word_q + CNT_W'(1);
                        state_d = StSetup;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            word_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            bias_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            word_q  <= word_d;
            count_q <= count_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            bias_q  <= bias_d;
            last_q  <= last_d;
        end
    end

    // Chip stays selected between words of one fetch; output enable drops once data is taken.
    assign busy_o        = (state_q == StSetup) || (state_q == StWait) ||
                           (state_q == StCapture) || (state_q == StPresent);
    assign fm_ce_o       = busy_o;
    assign fm_oe_o       = (state_q == StSetup) || (state_q == StWait) || (state_q == StCapture);
    assign fm_we_o       = 1'b0;
    assign done_o        = (state_q == StDone);
    assign err_o         = err_q;
    assign fm_addr_o     = addr_q;
    assign out_valid_o   = valid_q;
    assign out_data_o    = data_q;
    assign out_is_bias_o = bias_q;
    assign out_last_o    = last_q;

endmodule

// File: tb/tb_fm_param_fetcher.sv
// Directed bench for fm_param_fetcher: flash model, scoreboard of expected
// words, and per-cycle checks of handshake, stall stability and timing.
module tb_fm_param_fetcher;

    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        layer_sel = 1'b0;
    logic [3:0]  neuron_idx = 4'd0;
    logic        busy, done, err, fm_ce, fm_oe, fm_we;
    logic [15:0] fm_addr, fm_data, out_data;
    logic        out_valid, out_ready, out_is_bias, out_last;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        logic        bias;
        logic        last;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0, nfail = 0;
    int          cyc = 0, acc_cnt = 0, last_acc_cyc = -1;
    int          ce_cnt = 0, err_cnt = 0, done_cnt = 0;
    int          stall_left = 0;
    bit          bp_en = 0, word_stalled = 0, tp_chk = 0, was_stalled = 0;
    logic [17:0] held;

    always #5 clk = ~clk;

    function automatic logic [15:0] flash_word(input logic [15:0] a);
        logic [31:0] t;
        t = 32'(a) * 32'd40503 + 32'h1234;
        return t[15:0] ^ {t[23:16], a[7:0]};
    endfunction

    assign fm_data = (fm_ce && fm_oe) ? flash_word(fm_addr) : 16'hDEAD;

    fm_param_fetcher dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .layer_sel_i  (layer_sel),
        .neuron_idx_i (neuron_idx),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .fm_ce_o      (fm_ce),
        .fm_oe_o      (fm_oe),
        .fm_we_o      (fm_we),
        .fm_addr_o    (fm_addr),
        .fm_data_i    (fm_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_data_o   (out_data),
        .out_is_bias_o(out_is_bias),
        .out_last_o   (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        if (fm_ce) ce_cnt++;
        if (err) err_cnt++;
        if (done) done_cnt++;
        if (out_valid && was_stalled) chk("stall_hold", 32'(held), 32'({out_is_bias, out_last, out_data}));
        was_stalled = out_valid && !out_ready;
        held = {out_is_bias, out_last, out_data};
        if (out_valid && out_ready) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("addr", 32'(fm_addr), 32'(e.addr));
                chk("data", 32'(out_data), 32'(e.data));
                chk("is_bias", 32'(out_is_bias), 32'(e.bias));
                chk("is_last", 32'(out_last), 32'(e.last));
                chk("oe_we_low", 32'({fm_oe, fm_we}), 32'd0);
            end
            if (tp_chk && last_acc_cyc >= 0) chk("interval", 32'(cyc - last_acc_cyc), 32'(WAIT + 3));
            last_acc_cyc = cyc;
            acc_cnt++;
            word_stalled = 0;
        end
    endtask

    // One clock: set ready, sample at negedge, return just after the rising edge.
    task automatic tick();
        if (bp_en && out_valid && stall_left == 0 && !word_stalled && acc_cnt[0]) begin
            stall_left = 5;
            word_stalled = 1;
        end
        out_ready = (stall_left == 0);
        @(negedge clk);
        monitor();
        if (stall_left > 0) stall_left--;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic push_words(input bit layer, input int idx);
        int base, n;
        exp_t e;
        base = layer ? 296 + idx * 3 : idx * 37;
        n    = layer ? 3 : 37;
        for (int i = 0; i < n; i++) begin
            e.addr = 16'(base + i);
            e.data = flash_word(16'(base + i));
            e.bias = (i == 0);
            e.last = (i == n - 1);
            sb.push_back(e);
        end
    endtask

    task automatic fetch(input bit layer, input int idx, input bit tp, input int second_at);
        int d0, e0, lat, t, n;
        n = layer ? 3 : 37;
        push_words(layer, idx);
        acc_cnt = 0;
        last_acc_cyc = -1;
        tp_chk = tp;
        d0 = done_cnt;
        e0 = err_cnt;
        layer_sel = layer;
        neuron_idx = 4'(idx);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        lat = 0;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
        chk("first_latency", 32'(lat), 32'(WAIT + 2));
        t = 0;
        while (done_cnt == d0 && t < 5000) begin
            if (t == second_at) begin
                start = 1'b1;
                layer_sel = 1'b0;
                neuron_idx = 4'd5;
            end
            tick();
            start = 1'b0;
            t++;
        end
        chk("done_seen", 32'(done_cnt != d0), 32'd1);
        chk("words_accepted", 32'(acc_cnt), 32'(n));
        chk("sb_drained", 32'(sb.size()), 32'd0);
        tick();
        tick();
        chk("done_once", 32'(done_cnt - d0), 32'd1);
        chk("busy_cleared", 32'(busy), 32'd0);
        chk("no_err_in_fetch", 32'(err_cnt - e0), 32'd0);
        sb.delete();
    endtask

    task automatic bad_req(input bit layer, input int idx);
        int c0, e0;
        c0 = ce_cnt;
        e0 = err_cnt;
        layer_sel = layer;
        neuron_idx = 4'(idx);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("err_pulse", 32'(err), 32'd1);
        chk("err_not_busy", 32'(busy), 32'd0);
        tick();
        chk("err_single", 32'(err), 32'd0);
        repeat (6) tick();
        chk("err_count", 32'(err_cnt - e0), 32'd1);
        chk("err_no_ce", 32'(ce_cnt - c0), 32'd0);
    endtask

    initial begin
        int d0, t;
        out_ready = 1'b1;
        tick();
        tick();
        chk("reset_ctrl", 32'({busy, done, err, fm_ce, fm_oe, fm_we, out_valid, out_is_bias,
                               out_last}), 32'd0);
        chk("reset_addr", 32'(fm_addr), 32'd0);
        chk("reset_data", 32'(out_data), 32'd0);
        rst = 1'b0;
        tick();

        fetch(1'b0, 0, 1'b1, -1);   // hidden 0: addresses 0..36
        fetch(1'b1, 9, 1'b1, -1);   // output 9: addresses 323..325

        bp_en = 1;
        fetch(1'b0, 7, 1'b0, -1);   // hidden 7 under backpressure: 259..295
        bp_en = 0;

        bad_req(1'b0, 8);
        bad_req(1'b1, 10);

        fetch(1'b0, 2, 1'b1, 20);   // second start mid-fetch must be ignored: 74..110

        // Reset while word 5 of hidden 3 is in flight.
        push_words(1'b0, 3);
        acc_cnt = 0;
        last_acc_cyc = -1;
        tp_chk = 0;
        layer_sel = 1'b0;
        neuron_idx = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        t = 0;
        while (acc_cnt < 5 && t < 500) begin
            tick();
            t++;
        end
        chk("reached_word5", 32'(acc_cnt), 32'd5);
        tick();
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        chk("midreset_ctrl", 32'({busy, done, err, fm_ce, fm_oe, fm_we, out_valid, out_is_bias,
                                  out_last}), 32'd0);
        chk("midreset_addr", 32'(fm_addr), 32'd0);
        chk("midreset_data", 32'(out_data), 32'd0);
        sb.delete();
        rst = 1'b0;
        repeat (5) tick();
        chk("midreset_no_done", 32'(done_cnt - d0), 32'd0);
        chk("midreset_idle", 32'({busy, fm_ce}), 32'd0);

        fetch(1'b1, 0, 1'b1, -1);   // output 0: addresses 296..298

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
